// File: rtl/mul16_pkg.sv
// Shared definitions for the 16x16 shift-add multiplier and its two-port arbiter.
package mul16_pkg;
    localparam int W     = 16;
    localparam int CNT_W = $clog2(W);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        CALC = 1'b1
    } state_t;

    typedef logic [0:0] req_id_t;
endpackage

// File: rtl/mul16_seq_core.sv
// Bit-serial unsigned shift-add multiplier datapath: one multiplier bit per step.
module mul16_seq_core
    import mul16_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             step,
    input  logic [W-1:0]     a,
    input  logic [W-1:0]     b,
    output logic             last,
    output logic [2*W-1:0]   prod
);
    logic [2*W-1:0] mcand_reg;
    logic [W-1:0]   mplier_reg;
    logic [2*W-1:0] acc_reg;
    logic [2*W-1:0] acc_next;
    logic [CNT_W-1:0] cnt_reg;

    // prod includes the current step's partial product so the final value is
    // available on the same edge that performs the last iteration.
    assign acc_next = acc_reg + (mplier_reg[0] ? mcand_reg : '0);
    assign prod     = acc_next;
    assign last     = (cnt_reg == CNT_W'(W-1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand_reg  <= '0;
            mplier_reg <= '0;
            acc_reg    <= '0;
            cnt_reg    <= '0;
        end else if (load) begin
            mcand_reg  <= {{W{1'b0}}, a};
            mplier_reg <= b;
            acc_reg    <= '0;
            cnt_reg    <= '0;
        end else if (step) begin
            acc_reg    <= acc_next;
            mcand_reg  <= mcand_reg << 1;
            mplier_reg <= mplier_reg >> 1;
            cnt_reg    <= cnt_reg + CNT_W'(1);
        end
    end
endmodule

// File: rtl/mul16_arbiter.sv
// Two-requester front end for the shared shift-add multiplier.
// Define MUL16_ARB_RR_EN for round-robin ties; otherwise requester 0 has fixed priority.
module mul16_arbiter
    import mul16_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0,
    input  logic [W-1:0]     a0,
    input  logic [W-1:0]     b0,
    input  logic             req1,
    input  logic [W-1:0]     a1,
    input  logic [W-1:0]     b1,
    output logic             ack0,
    output logic             ack1,
    output logic             done0,
    output logic             done1,
    output logic [2*W-1:0]   yout,
    output logic             busy
);
    state_t         state_reg;
    req_id_t        gnt_id_reg;
    req_id_t        gnt_sel;
    logic           start;
    logic           core_last;
    logic [2*W-1:0] core_prod;
    logic [W-1:0]   sel_a;
    logic [W-1:0]   sel_b;
    logic           ack0_reg, ack1_reg, done0_reg, done1_reg;
    logic [2*W-1:0] yout_reg;

`ifdef MUL16_ARB_RR_EN
    req_id_t last_gnt_reg;

    always_comb begin
        gnt_sel = 1'b0;
        if (req0 && req1)
            gnt_sel = ~last_gnt_reg;
        else if (!req0)
            gnt_sel = 1'b1;
    end

    // Resets to 1 so that requester 0 takes the first tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            last_gnt_reg <= 1'b1;
        else if (start)
            last_gnt_reg <= gnt_sel;
    end
`else
    assign gnt_sel = req0 ? 1'b0 : 1'b1;
`endif

    assign start = (state_reg == IDLE) && (req0 || req1);
    assign sel_a = gnt_sel[0] ? a1 : a0;
    assign sel_b = gnt_sel[0] ? b1 : b0;

    mul16_seq_core u_core (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (start),
        .step  (state_reg == CALC),
        .a     (sel_a),
        .b     (sel_b),
        .last  (core_last),
        .prod  (core_prod)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= IDLE;
            gnt_id_reg <= 1'b0;
            ack0_reg   <= 1'b0;
            ack1_reg   <= 1'b0;
            done0_reg  <= 1'b0;
            done1_reg  <= 1'b0;
            yout_reg   <= '0;
        end else begin
            ack0_reg  <= start && (gnt_sel == 1'b0);
            ack1_reg  <= start && (gnt_sel == 1'b1);
            done0_reg <= 1'b0;
            done1_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        gnt_id_reg <= gnt_sel;
                        state_reg  <= CALC;
                    end
                end
                CALC: begin
                    if (core_last) begin
                        yout_reg  <= core_prod;
                        done0_reg <= (gnt_id_reg == 1'b0);
                        done1_reg <= (gnt_id_reg == 1'b1);
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign ack0  = ack0_reg;
    assign ack1  = ack1_reg;
    assign done0 = done0_reg;
    assign done1 = done1_reg;
    assign yout  = yout_reg;
    assign busy  = (state_reg == CALC);
endmodule

// File: tb/tb_mul16_arbiter.sv
// Directed-vector bench for mul16_arbiter; expected products are hand-computed constants.
`timescale 1ns/1ps
module tb_mul16_arbiter;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req0 = 1'b0, req1 = 1'b0;
    logic [15:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
    logic        ack0, ack1, done0, done1, busy;
    logic [31:0] yout;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    mul16_arbiter dut (
        .clk   (clk),
        .rst_n (rst_n),
        .req0  (req0),
        .a0    (a0),
        .b0    (b0),
        .req1  (req1),
        .a1    (a1),
        .b1    (b1),
        .ack0  (ack0),
        .ack1  (ack1),
        .done0 (done0),
        .done1 (done1),
        .yout  (yout),
        .busy  (busy)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one request from IDLE, check ack, latency, done routing and product.
    task automatic run_op(input int id, input logic [15:0] a, input logic [15:0] b,
                          input logic [31:0] exp);
        int n;
        if (id == 0) begin req0 = 1'b1; a0 = a; b0 = b; end
        else         begin req1 = 1'b1; a1 = a; b1 = b; end
        tick();
        check("op_ack", 64'({ack1, ack0}), (id == 0) ? 64'd1 : 64'd2);
        check("op_busy", 64'(busy), 64'd1);
        req0 = 1'b0; req1 = 1'b0;
        a0 = 16'hDEAD; b0 = 16'hBEEF; a1 = 16'hDEAD; b1 = 16'hBEEF;
        n = 0;
        while (!(done0 || done1) && n < 40) begin
            tick();
            n++;
        end
        check("op_latency", 64'(n), 64'd16);
        check("op_done", 64'({done1, done0}), (id == 0) ? 64'd1 : 64'd2);
        check("op_yout", 64'(yout), 64'(exp));
        $display("op req%0d a=%0d b=%0d -> yout=0x%0h latency=%0d", id, a, b, yout, n);
        tick();
        check("op_idle", 64'({busy, done1, done0}), 64'd0);
    endtask

    initial begin
        int n, got_id, e, nack, ndone, ntie;
        int ack_e[2];
        int done_e[2];
        int order[4];
        bit seen_done;

        // Reset state
        #2;
        check("rst_outputs", 64'({ack0, ack1, done0, done1, busy}), 64'd0);
        check("rst_yout", 64'(yout), 64'd0);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        tick();

        run_op(0, 16'd3, 16'd5, 32'd15);
        run_op(1, 16'hFFFF, 16'hFFFF, 32'hFFFE0001);

        // Tie with both requests held
`ifdef MUL16_ARB_RR_EN
        order = '{0, 1, 0, 1};
        ntie = 4;
`else
        order = '{0, 0, 0, 0};
        ntie = 3;
`endif
        a0 = 16'd11; b0 = 16'd13; a1 = 16'd17; b1 = 16'd19;
        req0 = 1'b1; req1 = 1'b1;
        for (int k = 0; k < ntie; k++) begin
            n = 0;
            while (!(ack0 || ack1) && n < 40) begin tick(); n++; end
            check("tie_ack_seen", 64'(ack0 || ack1), 64'd1);
            got_id = ack1 ? 1 : 0;
            check("tie_order", 64'(got_id), 64'(order[k]));
            n = 0;
            while (!(done0 || done1) && n < 40) begin tick(); n++; end
            check("tie_done", 64'({done1, done0}), (got_id == 0) ? 64'd1 : 64'd2);
            check("tie_yout", 64'(yout), (got_id == 0) ? 64'd143 : 64'd323);
            $display("tie grant=%0d -> yout=%0d", got_id, yout);
            if (k == ntie - 1) begin req0 = 1'b0; req1 = 1'b0; end
        end
        tick();
        tick();
        check("tie_idle", 64'(busy), 64'd0);

        // Reset mid-operation
        req0 = 1'b1; a0 = 16'd100; b0 = 16'd200;
        tick();
        req0 = 1'b0;
        for (int k = 0; k < 8; k++) tick();
        rst_n = 1'b0;
        #1;
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_yout", 64'(yout), 64'd0);
        check("midrst_done", 64'({done1, done0, ack1, ack0}), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen_done = 1'b0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (done0 || done1) seen_done = 1'b1;
        end
        check("midrst_no_done", 64'(seen_done), 64'd0);
        $display("reset mid-CALC -> busy=%0d yout=0x%0h", busy, yout);
        run_op(0, 16'd7, 16'd9, 32'd63);

        run_op(0, 16'd0, 16'd1234, 32'd0);

        // Back-to-back with req0 held through done
        a0 = 16'd5; b0 = 16'd6;
        req0 = 1'b1;
        nack = 0; ndone = 0;
        ack_e = '{0, 0}; done_e = '{0, 0};
        for (e = 1; e <= 45; e++) begin
            tick();
            if (ack0 && nack < 2) begin
                ack_e[nack] = e;
                nack++;
                if (nack == 2) req0 = 1'b0;
            end
            if (done0 && ndone < 2) begin
                check("b2b_yout", 64'(yout), 64'd30);
                done_e[ndone] = e;
                ndone++;
            end
        end
        check("b2b_counts", 64'({nack[3:0], ndone[3:0]}), 64'h22);
        check("b2b_done1", 64'(done_e[0] - ack_e[0]), 64'd16);
        check("b2b_ack2", 64'(ack_e[1] - ack_e[0]), 64'd17);
        check("b2b_done2", 64'(done_e[1] - ack_e[0]), 64'd33);
        $display("back-to-back ack@%0d,%0d done@%0d,%0d", ack_e[0], ack_e[1], done_e[0], done_e[1]);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
